// File: rtl/snn_mac_pkg.sv
// Shared types, default widths and the saturating adder for the synaptic accumulator.
package snn_mac_pkg;

    localparam int unsigned DEF_NUM_CONN = 8;
    localparam int unsigned DEF_ADDR_W   = 12;
    localparam int unsigned DEF_WEIGHT_W = 16;
    localparam int unsigned DEF_ACC_W    = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Signed add clamped to the range of an acc_w-bit two's-complement value.
    // Operands arrive sign-extended to 64 bits; the sum is formed in 65 bits so it never wraps.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                   input logic signed [63:0] w,
                                                   input int unsigned        acc_w);
        logic signed [64:0] sum;
        logic signed [64:0] max_v;
        logic signed [64:0] min_v;
        sum   = 65'(acc) + 65'(w);
        max_v = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
        min_v = -(65'sd1 <<< (acc_w - 1));
        if (sum > max_v) begin
            return 64'(max_v);
        end else if (sum < min_v) begin
            return 64'(min_v);
        end
        return 64'(sum);
    endfunction

endpackage

// File: rtl/synapse_mac_acc_if.sv
// Configuration, spike and result bundle of the synaptic accumulator.
// master = stimulus side, slave = accumulator side.
interface synapse_mac_acc_if
    import snn_mac_pkg::*;
#(
    parameter int unsigned NUM_CONN = DEF_NUM_CONN,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
    parameter int unsigned ACC_W    = DEF_ACC_W
) ();
    localparam int unsigned IDX_W = $clog2(NUM_CONN);

    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [WEIGHT_W-1:0] cfg_weight;
    logic                cfg_en;
    logic                cfg_ready;
    logic                spike_valid;
    logic [ADDR_W-1:0]   spike_addr;
    logic                timestep_end;
    logic [ACC_W-1:0]    acc_out;
    logic                acc_valid;
    logic                busy;
    logic                ts_overrun;

    modport master (
        output cfg_we, cfg_idx, cfg_addr, cfg_weight, cfg_en,
        output spike_valid, spike_addr, timestep_end,
        input  cfg_ready, acc_out, acc_valid, busy, ts_overrun
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_addr, cfg_weight, cfg_en,
        input  spike_valid, spike_addr, timestep_end,
        output cfg_ready, acc_out, acc_valid, busy, ts_overrun
    );

endinterface

// File: rtl/synapse_addr_cam.sv
// Address comparator array: one match bit per enabled table entry whose address equals the
// incoming spike address. All-zero when no spike is presented.
module synapse_addr_cam #(
    parameter int unsigned NUM_CONN = 8,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic                             i_spike_valid,
    input  logic [ADDR_W-1:0]                i_spike_addr,
    input  logic [NUM_CONN-1:0][ADDR_W-1:0]  i_tab_addr,
    input  logic [NUM_CONN-1:0]              i_tab_en,
    output logic [NUM_CONN-1:0]              o_match
);

    // Parallel compare; duplicates in the table raise several bits at once.
    always_comb begin
        o_match = '0;
        for (int i = 0; i < NUM_CONN; i++) begin
            o_match[i] = i_spike_valid && i_tab_en[i] && (i_tab_addr[i] == i_spike_addr);
        end
    end

endmodule

// File: rtl/synapse_mac_acc.sv
// Synaptic accumulator for one neuron: spikes are matched against a loadable
// (address, weight) table into a pending vector; at each timestep boundary the pending vector
// is snapshotted and the selected weights are summed with saturation, one per cycle.
// Build option SPARSE_SKIP_EN: visit only set snapshot bits (lowest first) instead of a fixed
// NUM_CONN-cycle scan; an empty snapshot goes straight to DONE.
module synapse_mac_acc
    import snn_mac_pkg::*;
#(
    parameter int unsigned NUM_CONN = DEF_NUM_CONN,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
    parameter int unsigned ACC_W    = DEF_ACC_W
) (
    input  logic             CLK_Mac,
    input  logic             RST_n,
    synapse_mac_acc_if.slave mac_if
);
    localparam int unsigned IDX_W = $clog2(NUM_CONN);

    state_e                            r_state;
    state_e                            w_state_next;
    logic [NUM_CONN-1:0][ADDR_W-1:0]   r_tab_addr;
    logic [NUM_CONN-1:0][WEIGHT_W-1:0] r_tab_weight;
    logic [NUM_CONN-1:0]               r_tab_en;
    logic [NUM_CONN-1:0]               r_pend;
    logic [NUM_CONN-1:0]               r_work;
    logic [NUM_CONN-1:0]               w_match;
    logic [NUM_CONN-1:0]               w_snap;
    logic signed [ACC_W-1:0]           r_acc;
    logic signed [ACC_W-1:0]           r_acc_out;
    logic signed [ACC_W-1:0]           w_acc_sum;
    logic signed [ACC_W-1:0]           w_acc_next;
    logic signed [WEIGHT_W-1:0]        w_weight;
    logic [IDX_W-1:0]                  w_sel_idx;
    logic                              w_last;
    logic                              w_ts_accept;
    logic                              w_cfg_wr;
    logic                              r_ovr;
`ifdef SPARSE_SKIP_EN
    logic [NUM_CONN-1:0]               w_work_rest;
`else
    logic [IDX_W-1:0]                  r_idx;
`endif

    synapse_addr_cam #(
        .NUM_CONN (NUM_CONN),
        .ADDR_W   (ADDR_W)
    ) u_cam (
        .i_spike_valid (mac_if.spike_valid),
        .i_spike_addr  (mac_if.spike_addr),
        .i_tab_addr    (r_tab_addr),
        .i_tab_en      (r_tab_en),
        .o_match       (w_match)
    );

    // Boundary acceptance and snapshot; a spike matched in the boundary cycle is included.
    always_comb begin
        w_ts_accept = mac_if.timestep_end && (r_state == IDLE);
        w_snap      = r_pend | w_match;
        w_cfg_wr    = mac_if.cfg_we && (r_state == IDLE);
    end

`ifdef SPARSE_SKIP_EN
    // Priority encoder picks the lowest remaining work bit; last when nothing else remains.
    always_comb begin
        w_sel_idx = '0;
        for (int i = NUM_CONN - 1; i >= 0; i--) begin
            if (r_work[i]) begin
                w_sel_idx = IDX_W'(i);
            end
        end
        w_work_rest = r_work & ~({{(NUM_CONN - 1){1'b0}}, 1'b1} << w_sel_idx);
        w_last      = (w_work_rest == '0);
    end
`else
    // Fixed scan: entry r_idx is visited this cycle.
    always_comb begin
        w_sel_idx = r_idx;
        w_last    = (r_idx == IDX_W'(NUM_CONN - 1));
    end
`endif

    // Saturating add of the selected weight, skipped when its work bit is clear.
    always_comb begin
        w_weight   = signed'(r_tab_weight[w_sel_idx]);
        w_acc_sum  = ACC_W'(sat_add(64'(r_acc), 64'(w_weight), ACC_W));
        w_acc_next = r_work[w_sel_idx] ? w_acc_sum : r_acc;
    end

    // FSM state register.
    always_ff @(posedge CLK_Mac or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (mac_if.timestep_end) begin
`ifdef SPARSE_SKIP_EN
                    w_state_next = (w_snap == '0) ? DONE : ACCUM;
`else
                    w_state_next = ACCUM;
`endif
                end
            end
            ACCUM: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM-decoded outputs; acc_valid is high for the single DONE cycle.
    always_comb begin
        mac_if.busy       = (r_state != IDLE);
        mac_if.cfg_ready  = (r_state == IDLE);
        mac_if.acc_valid  = (r_state == DONE);
        mac_if.acc_out    = r_acc_out;
        mac_if.ts_overrun = r_ovr;
    end

    // Table writes, only accepted while idle.
    always_ff @(posedge CLK_Mac or negedge RST_n) begin
        if (!RST_n) begin
            r_tab_addr   <= '0;
            r_tab_weight <= '0;
            r_tab_en     <= '0;
        end else if (w_cfg_wr) begin
            for (int i = 0; i < NUM_CONN; i++) begin
                if (mac_if.cfg_idx == IDX_W'(i)) begin
                    r_tab_addr[i]   <= mac_if.cfg_addr;
                    r_tab_weight[i] <= mac_if.cfg_weight;
                    r_tab_en[i]     <= mac_if.cfg_en;
                end
            end
        end
    end

    // Pending collects matches continuously; cleared only when a boundary is accepted.
    always_ff @(posedge CLK_Mac or negedge RST_n) begin
        if (!RST_n) begin
            r_pend <= '0;
            r_work <= '0;
        end else begin
            r_pend <= w_ts_accept ? '0 : (r_pend | w_match);
            if (w_ts_accept) begin
                r_work <= w_snap;
            end
`ifdef SPARSE_SKIP_EN
            else if (r_state == ACCUM) begin
                r_work <= w_work_rest;
            end
`endif
        end
    end

    // Accumulator, scan index and the held result register.
    always_ff @(posedge CLK_Mac or negedge RST_n) begin
        if (!RST_n) begin
            r_acc     <= '0;
            r_acc_out <= '0;
`ifndef SPARSE_SKIP_EN
            r_idx     <= '0;
`endif
        end else begin
            if (w_ts_accept) begin
                r_acc <= '0;
`ifndef SPARSE_SKIP_EN
                r_idx <= '0;
`endif
            end else if (r_state == ACCUM) begin
                r_acc <= w_acc_next;
`ifndef SPARSE_SKIP_EN
                r_idx <= r_idx + IDX_W'(1);
`endif
            end
            // Result is captured on entry to DONE so it is stable during the valid cycle.
            if ((r_state == ACCUM) && w_last) begin
                r_acc_out <= w_acc_next;
            end
`ifdef SPARSE_SKIP_EN
            if (w_ts_accept && (w_snap == '0)) begin
                r_acc_out <= '0;
            end
`endif
        end
    end

    // Sticky overrun: a boundary while busy is dropped and flagged.
    always_ff @(posedge CLK_Mac or negedge RST_n) begin
        if (!RST_n) begin
            r_ovr <= 1'b0;
        end else if (mac_if.timestep_end && (r_state != IDLE)) begin
            r_ovr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_synapse_mac_acc.sv
// Bench for synapse_mac_acc: two instances (ACC_W=24 and ACC_W=16) share one stimulus stream;
// expected sums and due cycles are queued per instance and popped by monitors on acc_valid.
// Honours SPARSE_SKIP_EN for the expected latency.
module tb_synapse_mac_acc;
    localparam int unsigned NUM_CONN = 8;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned WEIGHT_W = 16;
`ifdef SPARSE_SKIP_EN
    localparam bit SPARSE = 1'b1;
`else
    localparam bit SPARSE = 1'b0;
`endif

    typedef struct {
        logic [23:0] val;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t q24[$];
    exp_t q16[$];

    logic                cfg_we = 1'b0;
    logic [2:0]          cfg_idx = '0;
    logic [ADDR_W-1:0]   cfg_addr = '0;
    logic [WEIGHT_W-1:0] cfg_weight = '0;
    logic                cfg_en = 1'b0;
    logic                spike_valid = 1'b0;
    logic [ADDR_W-1:0]   spike_addr = '0;
    logic                timestep_end = 1'b0;

    synapse_mac_acc_if #(.NUM_CONN(NUM_CONN), .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W), .ACC_W(24))
        ifc24 ();
    synapse_mac_acc_if #(.NUM_CONN(NUM_CONN), .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W), .ACC_W(16))
        ifc16 ();

    assign ifc24.cfg_we       = cfg_we;
    assign ifc24.cfg_idx      = cfg_idx;
    assign ifc24.cfg_addr     = cfg_addr;
    assign ifc24.cfg_weight   = cfg_weight;
    assign ifc24.cfg_en       = cfg_en;
    assign ifc24.spike_valid  = spike_valid;
    assign ifc24.spike_addr   = spike_addr;
    assign ifc24.timestep_end = timestep_end;
    assign ifc16.cfg_we       = cfg_we;
    assign ifc16.cfg_idx      = cfg_idx;
    assign ifc16.cfg_addr     = cfg_addr;
    assign ifc16.cfg_weight   = cfg_weight;
    assign ifc16.cfg_en       = cfg_en;
    assign ifc16.spike_valid  = spike_valid;
    assign ifc16.spike_addr   = spike_addr;
    assign ifc16.timestep_end = timestep_end;

    synapse_mac_acc #(.NUM_CONN(NUM_CONN), .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W), .ACC_W(24))
        dut24 (.CLK_Mac(clk), .RST_n(rst_n), .mac_if(ifc24));
    synapse_mac_acc #(.NUM_CONN(NUM_CONN), .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W), .ACC_W(16))
        dut16 (.CLK_Mac(clk), .RST_n(rst_n), .mac_if(ifc16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop and compare value and arrival cycle on every acc_valid.
    always @(negedge clk) begin : mon24
        exp_t e;
        if (rst_n && ifc24.acc_valid) begin
            if (q24.size() == 0) begin
                check("spurious_valid24", 32'(ifc24.acc_valid), 32'd0);
            end else begin
                e = q24.pop_front();
                check("acc_out24", 32'(ifc24.acc_out), 32'(e.val));
                check("latency24", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (rst_n && ifc16.acc_valid) begin
            if (q16.size() == 0) begin
                check("spurious_valid16", 32'(ifc16.acc_valid), 32'd0);
            end else begin
                e = q16.pop_front();
                check("acc_out16", 32'(ifc16.acc_out), 32'(e.val[15:0]));
                check("latency16", cyc, e.due);
            end
        end
    end

    task automatic cfg_write(input int idx, input int addr, input int w, input bit en);
        cfg_we     = 1'b1;
        cfg_idx    = 3'(idx);
        cfg_addr   = 12'(addr);
        cfg_weight = 16'(w);
        cfg_en     = en;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic spike(input int addr);
        spike_valid = 1'b1;
        spike_addr  = 12'(addr);
        @(negedge clk);
        spike_valid = 1'b0;
    endtask

    // Boundary pulse; queues expectations (due = edge E + latency) when push is set.
    task automatic ts_end(input int exp24, input int exp16, input int pop, input bit push);
        exp_t e;
        int unsigned lat;
        timestep_end = 1'b1;
        @(posedge clk);
        #1;
        lat = SPARSE ? pop : NUM_CONN;
        if (push) begin
            e.due = cyc + lat;
            e.val = 24'(exp24);
            q24.push_back(e);
            e.val = 24'(exp16);
            q16.push_back(e);
        end
        @(negedge clk);
        timestep_end = 1'b0;
        check("busy_after_ts", 32'(ifc24.busy), 32'd1);
        check("cfg_ready_busy", 32'(ifc24.cfg_ready), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ifc24.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(ifc24.busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_acc_out", 32'(ifc24.acc_out), 32'd0);
        check("rst_acc_valid", 32'(ifc24.acc_valid), 32'd0);
        check("rst_busy", 32'(ifc24.busy), 32'd0);
        check("rst_overrun", 32'(ifc24.ts_overrun), 32'd0);
        check("rst_cfg_ready", 32'(ifc24.cfg_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sum: 100 + (-30)
        for (int i = 0; i < 8; i++) begin
            cfg_write(i, 8 + i, (i == 0) ? 100 : ((i == 1) ? -30 : 0), 1'b1);
        end
        spike(8);
        spike(9);
        ts_end(70, 70, 2, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("acc_out_hold", 32'(ifc24.acc_out), 32'd70);

        // Duplicate address (entries 2, 5), disabled entry 4, repeated spike, miss
        cfg_write(2, 12, 10, 1'b1);
        cfg_write(4, 12, 500, 1'b0);
        cfg_write(5, 12, 20, 1'b1);
        spike(12);
        spike(12);
        spike(99);
        ts_end(30, 30, 2, 1'b1);
        wait_idle();

        // Saturation: 16-bit instance clamps, 24-bit one holds the exact sum
        for (int i = 0; i < 8; i++) cfg_write(i, 8 + i, 32'h7FFF, 1'b1);
        for (int i = 0; i < 8; i++) spike(8 + i);
        ts_end(262136, 32767, 8, 1'b1);
        wait_idle();
        for (int i = 0; i < 8; i++) cfg_write(i, 8 + i, -32768, 1'b1);
        for (int i = 0; i < 8; i++) spike(8 + i);
        ts_end(-262144, -32768, 8, 1'b1);
        wait_idle();

        // Overrun and rollover of spikes captured during ACCUM
        cfg_write(0, 8, 100, 1'b1);
        cfg_write(1, 9, -30, 1'b1);
        for (int i = 2; i < 8; i++) cfg_write(i, 100 + i, 0, 1'b0);
        check("ovr_clear", 32'(ifc24.ts_overrun), 32'd0);
        spike(8);
        ts_end(100, 100, 1, 1'b1);
        spike_valid  = 1'b1;
        spike_addr   = 12'd9;
        timestep_end = 1'b1;
        @(negedge clk);
        spike_valid  = 1'b0;
        timestep_end = 1'b0;
        wait_idle();
        check("ovr_set", 32'(ifc24.ts_overrun), 32'd1);
        ts_end(-30, -30, 1, 1'b1);
        wait_idle();
        check("ovr_sticky", 32'(ifc24.ts_overrun), 32'd1);

        // Table write while busy is ignored
        spike(8);
        ts_end(100, 100, 1, 1'b1);
        cfg_write(0, 8, 7, 1'b1);
        wait_idle();
        spike(8);
        ts_end(100, 100, 1, 1'b1);
        wait_idle();

        // Reset mid-accumulation: no result, outputs cleared at once, table cleared
        spike(8);
        ts_end(0, 0, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc_out", 32'(ifc24.acc_out), 32'd0);
        check("mid_rst_acc_out16", 32'(ifc16.acc_out), 32'd0);
        check("mid_rst_busy", 32'(ifc24.busy), 32'd0);
        check("mid_rst_valid", 32'(ifc24.acc_valid), 32'd0);
        check("mid_rst_overrun", 32'(ifc24.ts_overrun), 32'd0);
        check("mid_rst_cfg_ready", 32'(ifc24.cfg_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        spike(8);
        ts_end(0, 0, 0, 1'b1);
        wait_idle();

        // Sparse pattern {1,6}
        cfg_write(1, 20, 5, 1'b1);
        cfg_write(6, 21, 7, 1'b1);
        spike(20);
        spike(21);
        ts_end(12, 12, 2, 1'b1);
        wait_idle();

        repeat (3) @(negedge clk);
        check("q24_drained", q24.size(), 32'd0);
        check("q16_drained", q16.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synapse_mac_acc.md
Name: synapse_mac_acc

Overview:
- Parametrised synaptic accumulator for one neuron.
- Incoming spike source addresses are matched against a runtime-loadable table of (source address, weight) entries, and the matches are recorded as pending spikes.
- At each timestep boundary the pending vector is snapshotted, then the matching signed fixed-point weights are summed, with saturation, over successive cycles.
- The sum goes to the neuron membrane update stage with a one-cycle valid pulse. Successor of the fixed 5-connection MAC: configurable depth/widths, loadable table, handshake, overrun detection.

Parameters:
- NUM_CONN, 8, number of synapse entries (2..64)
- ADDR_W, 12, source address width
- WEIGHT_W, 16, signed two's-complement weight width
- ACC_W, 24, signed accumulator/output width (ACC_W >= WEIGHT_W)

Ports:
- CLK_Mac  in  1  clock, all state on rising edge
- RST_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  table write strobe
- cfg_idx  in  $clog2(NUM_CONN)  entry index
- cfg_addr  in  ADDR_W  source address for entry
- cfg_weight  in  WEIGHT_W  weight for entry
- cfg_en  in  1  entry enable bit
- cfg_ready  out  1  table writable (= not busy)
- spike_valid  in  1  spike present
- spike_addr  in  ADDR_W  spike source address
- timestep_end  in  1  one-cycle timestep boundary pulse
- acc_out  out  ACC_W  saturated weighted sum
- acc_valid  out  1  one-cycle pulse, acc_out new
- busy  out  1  accumulation in progress
- ts_overrun  out  1  sticky: timestep_end arrived while busy

Behaviour:
- Reset (async, RST_n=0): table entries disabled, addr/weight = 0; pending and work vectors 0; state IDLE; acc_out=0, acc_valid=0, busy=0, ts_overrun=0, cfg_ready=1. Reset mid-accumulation aborts the accumulation with no acc_valid.
- Table write: cfg_we && cfg_ready writes entry cfg_idx at the clock edge. cfg_we while busy is ignored. Written entries take effect for spikes from the next cycle.
- Spike capture: when spike_valid is high, every enabled entry with addr == spike_addr sets its pending bit. Duplicate matches set multiple bits. No match means the spike is dropped. Repeated spikes from one source within a timestep count once.
- Boundary in IDLE: timestep_end in IDLE copies pending (including any spike matched in the same cycle) into work, clears pending, and moves to ACCUM with idx=0 and acc=0.
- Spikes during ACCUM keep updating pending for the next timestep.
- FSM: IDLE -> ACCUM (timestep_end) -> DONE -> IDLE.
  - ACCUM: one entry per cycle. If work[idx], acc <= sat(acc + sign_ext(weight[idx])). idx++. Leave after idx == NUM_CONN-1.
  - DONE: acc_out <= acc; acc_valid=1 for exactly this cycle; back to IDLE.
- Latency (default build): timestep_end sampled at edge E gives acc_valid high in the cycle following edge E+NUM_CONN. busy is high from edge E until acc_valid drops.
- Saturation: clamp at every add to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Never wraps.
- Overrun: timestep_end while busy sets ts_overrun (sticky until reset). That pulse is ignored and pending is not snapshotted; the spikes roll into the next accepted timestep.
- Empty timestep: all-zero work still yields acc_valid with acc_out=0.
- acc_out holds its value between pulses.

Optional Feature:
- SPARSE_SKIP_EN defined: ACCUM visits only set bits of work, lowest index first, using a priority encoder, one add per cycle. An all-zero work vector goes IDLE -> DONE directly. acc_valid comes popcount(work)+1 cycles after edge E (minimum 1). Results are identical to the default build.
- Undefined: fixed NUM_CONN-cycle scan as above.

Decomposition:
- Package snn_mac_pkg:
  - state enum (IDLE, ACCUM, DONE)
  - default width localparams
  - saturating-add function sat_add(acc, w) parameterised by ACC_W
- Sub-module synapse_addr_cam: the enabled-entry address comparator array producing the NUM_CONN match vector. Instantiated once.

Test Plan (NUM_CONN=8, WEIGHT_W=16, ACC_W=24 unless noted):
- Basic sum: load entries 0..7 with addrs 8..15, weights 100,-30,0,...; spikes 8 and 9; timestep_end -> acc_valid 9 cycles later, acc_out=70; busy high throughout.
- Duplicate/miss: entries 2 and 5 both addr 12 (weights 10, 20); spike 12 twice plus spike 99 -> acc_out=30.
- Saturation: ACC_W=16, all 8 weights 0x7FFF, all hit -> acc_out=0x7FFF. All weights 0x8000 -> acc_out=0x8000.
- Overrun/rollover: spike 8, timestep_end, spike 9 during ACCUM, second timestep_end while busy -> first acc_out=100, ts_overrun=1. Next timestep_end in IDLE -> acc_out=-30.
- Reset/config guard: cfg_we during busy is ignored (cfg_ready=0). Assert RST_n=0 mid-ACCUM -> outputs zero immediately, no acc_valid, table cleared.
- SPARSE_SKIP_EN: bits {1,6} set -> acc_valid 3 cycles after edge E. Empty vector -> acc_valid after 1 cycle with acc_out=0.
